// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } sipo_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output port bundle of the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
    logic             clr_overrun;
    logic             busy;

    modport master (
        output bit_in, bit_valid, frame_start, word_ready, clr_overrun,
        input  word_out, word_valid, overrun, busy
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, word_ready, clr_overrun,
        output word_out, word_valid, overrun, busy
    );
endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; drops and flags words that find it full.
module sipo_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             ovr
);
    logic accept_s;
    logic drop_s;

    // Load is allowed when empty or being drained in the same cycle.
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (load) begin
            accept_s = !valid || ready;
            drop_s   = valid && !ready;
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Holding register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (accept_s) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (drop_s) begin
            ovr <= 1'b1;
        end else if (clr) begin
            ovr <= 1'b0;
        end
    end
endmodule

// File: rtl/sipo_deserializer.sv
// Assembles MSB-first words from a qualified serial bit stream and hands them to a holding register.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    sipo_deserializer_if.slave sif
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    sipo_state_t      state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] word_s;
    logic             complete_s;

    // A frame_start in the final-bit cycle restarts the word instead of completing it.
    always_comb begin
        word_s     = {sr_r[WIDTH-2:0], sif.bit_in};
        complete_s = 1'b0;
        if ((state_r == COLLECT) && !sif.frame_start && sif.bit_valid && (cnt_r == LAST)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
    end

    // Framing FSM with bit counter and shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sr_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sif.frame_start) begin
                        state_r <= COLLECT;
                        cnt_r   <= sif.bit_valid ? ONE : '0;
                        if (sif.bit_valid) begin
                            sr_r <= word_s;
                        end
                    end
                end
                COLLECT: begin
                    if (sif.bit_valid) begin
                        sr_r <= word_s;
                    end
                    if (sif.frame_start) begin
                        cnt_r <= sif.bit_valid ? ONE : '0;
                    end else if (sif.bit_valid) begin
                        if (cnt_r == LAST) begin
                            cnt_r   <= '0;
                            state_r <= CONTINUOUS ? COLLECT : IDLE;
                        end else begin
                            cnt_r <= cnt_r + ONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign sif.busy = (state_r == COLLECT);

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk  (clk),
        .rst  (rst),
        .load (complete_s),
        .din  (word_s),
        .ready(sif.word_ready),
        .clr  (sif.clr_overrun),
        .dout (sif.word_out),
        .valid(sif.word_valid),
        .ovr  (sif.overrun)
    );
endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized scoreboard bench for sipo_deserializer: one CONTINUOUS=1 and one CONTINUOUS=0 instance share stimulus.
module tb_sipo_deserializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) if0 ();
    sipo_deserializer_if #(.WIDTH(W)) if1 ();

    sipo_deserializer #(.WIDTH(W), .CONTINUOUS(1'b1)) dut0 (.clk(clk), .rst(rst), .sif(if0));
    sipo_deserializer #(.WIDTH(W), .CONTINUOUS(1'b0)) dut1 (.clk(clk), .rst(rst), .sif(if1));

    int checks = 0;
    int errors = 0;

    // Reference model: word in progress as an integer, expected deliveries as queues.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int  m_cnt  [2];
    int  m_acc  [2];
    bit  m_busy [2];
    bit  m_full [2];
    bit  m_ovr  [2];
    bit  m_cont [2];

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qfront(input int k);
        return (k == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    task automatic qpush(input int k, input logic [W-1:0] w);
        if (k == 0) q0.push_back(w); else q1.push_back(w);
    endtask

    task automatic qpop(input int k);
        logic [W-1:0] d;
        if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_busy[k] = 1'b0; m_full[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit fs, input bit bv, input bit b,
                              input bit rdy, input bit clr);
        bit done;
        bit drain;
        bit drop;
        logic [W-1:0] w;
        done  = 1'b0;
        drop  = 1'b0;
        w     = '0;
        drain = m_full[k] && rdy;
        if (fs) begin
            m_busy[k] = 1'b1;
            m_cnt[k]  = bv ? 1 : 0;
            m_acc[k]  = bv ? int'(b) : 0;
        end else if (m_busy[k] && bv) begin
            m_acc[k] = m_acc[k] * 2 + int'(b);
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == W) begin
                done     = 1'b1;
                w        = W'(m_acc[k]);
                m_cnt[k] = 0;
                m_acc[k] = 0;
                if (!m_cont[k]) m_busy[k] = 1'b0;
            end
        end
        if (done) begin
            if (!m_full[k] || drain) begin
                qpush(k, w);
                m_full[k] = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (drain) begin
            m_full[k] = 1'b0;
        end
        if (drop) m_ovr[k] = 1'b1;
        else if (clr) m_ovr[k] = 1'b0;
    endtask

    // Monitor: samples just before each rising edge and pops on handshake.
    task automatic monitor_check(input int k, input logic valid, input logic [W-1:0] word,
                                 input logic ovr, input logic busy, input logic rdy);
        chk("word_valid", k, int'(valid), (qsize(k) != 0) ? 1 : 0);
        if (valid && qsize(k) != 0) begin
            chk("word_out", k, int'(word), qfront(k));
            if (rdy) qpop(k);
        end
        chk("overrun", k, int'(ovr), int'(m_ovr[k]));
        chk("busy", k, int'(busy), int'(m_busy[k]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #4;
            monitor_check(0, if0.word_valid, if0.word_out, if0.overrun, if0.busy, if0.word_ready);
            monitor_check(1, if1.word_valid, if1.word_out, if1.overrun, if1.busy, if1.word_ready);
        end
    end

    task automatic drive(input bit fs, input bit bv, input bit b, input bit rdy, input bit clr);
        if0.frame_start = fs; if0.bit_valid = bv; if0.bit_in = b; if0.word_ready = rdy; if0.clr_overrun = clr;
        if1.frame_start = fs; if1.bit_valid = bv; if1.bit_in = b; if1.word_ready = rdy; if1.clr_overrun = clr;
    endtask

    task automatic cyc(input bit fs, input bit bv, input bit b, input bit rdy, input bit clr);
        @(negedge clk);
        drive(fs, bv, b, rdy, clr);
        @(posedge clk);
        #1;
        model_step(0, fs, bv, b, rdy, clr);
        model_step(1, fs, bv, b, rdy, clr);
    endtask

    task automatic send_word(input bit fs, input logic [W-1:0] w, input bit rdy, input bit rdy_last,
                             input bit clr_last);
        for (int i = W - 1; i >= 0; i--) begin
            cyc((i == W - 1) ? fs : 1'b0, 1'b1, w[i], (i == 0) ? rdy_last : rdy,
                (i == 0) ? clr_last : 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit rdy, input bit clr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, clr);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_word_out", 0, int'(if0.word_out), 0);
        chk("rst_word_valid", 0, int'(if0.word_valid), 0);
        chk("rst_overrun", 0, int'(if0.overrun), 0);
        chk("rst_busy", 0, int'(if0.busy), 0);
        chk("rst_busy", 1, int'(if1.busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_cont[0] = 1'b1;
        m_cont[1] = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_word_out", 0, int'(if0.word_out), 0);
        chk("reset_word_valid", 0, int'(if0.word_valid), 0);
        chk("reset_overrun", 0, int'(if0.overrun), 0);
        chk("reset_busy", 0, int'(if0.busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single word with consumer ready
        send_word(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // 2: consumer stalled across two words; second one is dropped
        async_reset();
        send_word(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        send_word(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);

        // 3: drain coincides with the next completion
        async_reset();
        send_word(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        send_word(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // 4: partial word discarded by frame_start, then set-versus-clear on overrun
        async_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_word(1'b1, 8'h81, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        send_word(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);

        // 5: reset partway through a word, then a clean word
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        async_reset();
        send_word(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);

        // 6: back-to-back words after one frame_start (instance 1 keeps only the first)
        send_word(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        send_word(1'b0, 8'hC3, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        send_word(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            end
        end

        idle(4, 1'b1, 1'b1);
        chk("queue_empty", 0, q0.size(), 0);
        chk("queue_empty", 1, q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
